// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  cpu_types_pkg
//  Types shared by the execute and memory stages of the 5-stage MIPS pipeline.
//  Revision: 1.0
// ============================================================================
package cpu_types_pkg;

  typedef enum logic [2:0] {
    PC_NXT = 3'd0,
    PC_BEQ = 3'd1,
    PC_BNE = 3'd2,
    PC_J   = 3'd3,
    PC_JR  = 3'd4,
    PC_JAL = 3'd5
  } pcsrc_t;

  typedef struct packed {
    logic        halt;
    logic [4:0]  wsel;
    logic        RegWr;
    logic        MemToReg;
    logic        WrLinkReg;
    logic        MemRd;
    logic        MemWr;
    pcsrc_t      PCSrc;
    logic [31:0] aluOut;
    logic        zero;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] b_addr;
    logic [31:0] j_addr;
    logic [31:0] pc;
  } ex_out_t;

  typedef struct packed {
    logic        RegWr;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        halt;
  } wb_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    MS_IDLE   = ST_IDLE,
    MS_ACCESS = ST_ACCESS,
    MS_DONE   = ST_DONE
  } mem_state_t;

  function automatic logic is_mem_op(input ex_out_t e);
    return e.MemRd | e.MemWr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_req_fsm.sv
`default_nettype none
// ============================================================================
//  mem_req_fsm
//  Data-cache request sequencer: state, request strobes, load buffer, stall count.
//  Revision: 1.0
// ============================================================================
module mem_req_fsm
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             adv_i,
  input  logic             start_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic             dhit_i,
  input  logic [31:0]      dmemload_i,
  output mem_state_t       state_o,
  output logic             dmemREN_o,
  output logic             dmemWEN_o,
  output logic [31:0]      load_buf_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  mem_state_t       state_q, state_d;
  logic [31:0]      load_buf_q, load_buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_access;
  logic             rd_eff;

  assign in_access = (state_q == MS_ACCESS);
  // A write request takes priority over a simultaneous read flag.
  assign rd_eff    = rd_i & ~wr_i;

  always_comb begin
    state_d    = state_q;
    load_buf_d = load_buf_q;
    cnt_d      = cnt_q;
    case (state_q)
      MS_ACCESS: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + c_cnt_one;
        if (dhit_i) begin
          state_d = MS_DONE;
          if (rd_eff) load_buf_d = dmemload_i;
        end
      end
      default: begin
        if (adv_i) state_d = start_i ? MS_ACCESS : MS_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= MS_IDLE;
      load_buf_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_buf_q <= load_buf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign state_o     = state_q;
  assign dmemREN_o   = in_access & rd_eff;
  assign dmemWEN_o   = in_access & wr_i;
  assign load_buf_o  = load_buf_q;
  assign stall_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  mem_stage
//  MIPS memory stage: EX/MEM register, branch resolution, cache access, writeback.
//  Revision: 1.0
// ============================================================================
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  ex_out_t          ex_in,
  input  logic             ex_valid,
  input  logic             hold_i,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic             mem_stall,
  output logic             br_taken,
  output logic [31:0]      npc,
  output wb_t              wb_out,
  output logic             wb_valid,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt
);

  ex_out_t     exm_q, exm_d;
  logic        valid_q, valid_d;
  logic        halt_q, halt_d;
  mem_state_t  state;
  logic [31:0] load_buf;
  logic        adv;
  logic        start;
  logic        halt_blk;
  logic        br_cond;
  logic [31:0] wdat;

  assign mem_stall = (state == MS_ACCESS);
  assign adv       = ~mem_stall & ~hold_i;
  // A halt already sitting in the register blocks the op loaded behind it.
  assign halt_blk  = halt_q | (valid_q & exm_q.halt);
  assign start     = ex_valid & is_mem_op(ex_in) & ~halt_blk;

  always_comb begin
    exm_d   = exm_q;
    valid_d = valid_q;
    if (adv) begin
      exm_d   = ex_in;
      valid_d = ex_valid;
    end
  end

  assign halt_d = halt_q | (wb_valid & exm_q.halt);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exm_q   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      exm_q   <= exm_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end

  mem_req_fsm #(
    .CNT_W (CNT_W)
  ) u_req (
    .CLK         (CLK),
    .RST         (RST),
    .adv_i       (adv),
    .start_i     (start),
    .rd_i        (exm_q.MemRd),
    .wr_i        (exm_q.MemWr),
    .dhit_i      (dhit),
    .dmemload_i  (dmemload),
    .state_o     (state),
    .dmemREN_o   (dmemREN),
    .dmemWEN_o   (dmemWEN),
    .load_buf_o  (load_buf),
    .stall_cnt_o (stall_cnt)
  );

  always_comb begin
    br_cond = 1'b0;
    npc     = '0;
    case (exm_q.PCSrc)
      PC_BEQ: begin
        br_cond = exm_q.zero;
        npc     = exm_q.b_addr;
      end
      PC_BNE: begin
        br_cond = ~exm_q.zero;
        npc     = exm_q.b_addr;
      end
      PC_J, PC_JAL: begin
        br_cond = 1'b1;
        npc     = exm_q.j_addr;
      end
      PC_JR: begin
        br_cond = 1'b1;
        npc     = exm_q.rdat1;
      end
      default: ;
    endcase
  end

  // Gating with hold_i makes a held branch redirect once, when released.
  assign br_taken = valid_q & ~hold_i & br_cond;

  always_comb begin
    wdat = exm_q.aluOut;
    if (exm_q.MemToReg)       wdat = load_buf;
    else if (exm_q.WrLinkReg) wdat = exm_q.pc + 32'd4;
  end

  assign wb_valid  = valid_q & ~mem_stall;
  assign wb_out    = '{RegWr: exm_q.RegWr, wsel: exm_q.wsel, wdat: wdat, halt: exm_q.halt};
  assign dmemaddr  = exm_q.aluOut;
  assign dmemstore = exm_q.rdat2;
  assign halt_o    = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  tb_mem_stage
//  Table vectors, directed multi-cycle sequences and a random model check.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage;
  import cpu_types_pkg::*;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                CLK = 1'b0;
  logic                RST;
  ex_out_t             ex_in;
  logic                ex_valid, hold_i, dhit;
  logic [31:0]         dmemload;
  logic                dmemREN, dmemWEN, mem_stall, br_taken, wb_valid, halt_o;
  logic [31:0]         dmemaddr, dmemstore, npc;
  wb_t                 wb_out;
  logic [TB_CNT_W-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.CNT_W(TB_CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ex_in(ex_in), .ex_valid(ex_valid), .hold_i(hold_i),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .br_taken(br_taken), .npc(npc), .wb_out(wb_out), .wb_valid(wb_valid),
    .halt_o(halt_o), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    pcsrc_t      src;
    logic        zero;
    logic        wlink;
    logic        regwr;
    logic [4:0]  wsel;
    logic [31:0] alu, rdat1, baddr, jaddr, pc;
    logic        exp_br;
    logic [31:0] exp_npc, exp_wdat;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bubble();
    ex_in    = '0;
    ex_valid = 1'b0;
  endtask

  task automatic do_reset();
    bubble();
    hold_i = 1'b0;
    dhit   = 1'b0;
    RST    = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic load_lw(input logic [31:0] addr);
    ex_in          = '0;
    ex_in.MemRd    = 1'b1;
    ex_in.MemToReg = 1'b1;
    ex_in.RegWr    = 1'b1;
    ex_in.wsel     = 5'd7;
    ex_in.aluOut   = addr;
    ex_valid       = 1'b1;
  endtask

  // Reference model state for the random phase: one instruction in the stage,
  // busy while its cache access is outstanding.
  ex_out_t     m_ins;
  logic        m_valid, m_busy;
  logic [31:0] m_ldata;
  int          m_cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; ex_in = '0; ex_valid = 1'b0; hold_i = 1'b0; dhit = 1'b0; dmemload = '0;
    step();
    step();
    RST = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_mem_stall", 32'(mem_stall), 0);
    chk("rst_ren", 32'(dmemREN), 0);
    chk("rst_wen", 32'(dmemWEN), 0);
    chk("rst_br", 32'(br_taken), 0);
    chk("rst_halt", 32'(halt_o), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    chk("rst_addr", dmemaddr, 0);
    chk("rst_npc", npc, 0);

    // ---------------- single-cycle ops ----------------
    tbl[0] = '{PC_NXT, 1'b0, 1'b0, 1'b1, 5'd5,  32'h10, 32'h0,  32'h0,  32'h0,   32'h0,  1'b0, 32'h0,   32'h10};
    tbl[1] = '{PC_BEQ, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,  32'h0,  32'h40, 32'h0,   32'h0,  1'b1, 32'h40,  32'h0};
    tbl[2] = '{PC_BEQ, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,  32'h0,  32'h40, 32'h0,   32'h0,  1'b0, 32'h0,   32'h0};
    tbl[3] = '{PC_BNE, 1'b0, 1'b0, 1'b0, 5'd0,  32'h7,  32'h0,  32'h80, 32'h0,   32'h0,  1'b1, 32'h80,  32'h7};
    tbl[4] = '{PC_J,   1'b0, 1'b0, 1'b0, 5'd0,  32'h0,  32'h0,  32'h0,  32'h400, 32'h0,  1'b1, 32'h400, 32'h0};
    tbl[5] = '{PC_JR,  1'b0, 1'b0, 1'b0, 5'd0,  32'h0,  32'h88, 32'h0,  32'h0,   32'h0,  1'b1, 32'h88,  32'h0};
    tbl[6] = '{PC_JAL, 1'b0, 1'b1, 1'b1, 5'd31, 32'h99, 32'h0,  32'h0,  32'h300, 32'h20, 1'b1, 32'h300, 32'h24};
    for (int i = 0; i < 7; i++) begin
      ex_in           = '0;
      ex_in.PCSrc     = tbl[i].src;
      ex_in.zero      = tbl[i].zero;
      ex_in.WrLinkReg = tbl[i].wlink;
      ex_in.RegWr     = tbl[i].regwr;
      ex_in.wsel      = tbl[i].wsel;
      ex_in.aluOut    = tbl[i].alu;
      ex_in.rdat1     = tbl[i].rdat1;
      ex_in.b_addr    = tbl[i].baddr;
      ex_in.j_addr    = tbl[i].jaddr;
      ex_in.pc        = tbl[i].pc;
      ex_valid        = 1'b1;
      step();
      bubble();
      #1;
      chk($sformatf("vec%0d_br", i), 32'(br_taken), 32'(tbl[i].exp_br));
      if (tbl[i].exp_br) chk($sformatf("vec%0d_npc", i), npc, tbl[i].exp_npc);
      chk($sformatf("vec%0d_wbv", i), 32'(wb_valid), 1);
      chk($sformatf("vec%0d_wdat", i), wb_out.wdat, tbl[i].exp_wdat);
      chk($sformatf("vec%0d_regwr", i), 32'(wb_out.RegWr), 32'(tbl[i].regwr));
      chk($sformatf("vec%0d_stall", i), 32'(mem_stall), 0);
    end
    step();
    chk("bubble_wbv", 32'(wb_valid), 0);

    // ---------------- LW with dhit on the third ACCESS cycle ----------------
    load_lw(32'h100);
    step();
    bubble();
    for (int c = 0; c < 3; c++) begin
      dhit     = (c == 2);
      dmemload = (c == 2) ? 32'hDEADBEEF : 32'h1234_5678;
      #1;
      chk($sformatf("lw_ren%0d", c), 32'(dmemREN), 1);
      chk($sformatf("lw_wen%0d", c), 32'(dmemWEN), 0);
      chk($sformatf("lw_addr%0d", c), dmemaddr, 32'h100);
      chk($sformatf("lw_stall%0d", c), 32'(mem_stall), 1);
      chk($sformatf("lw_wbv%0d", c), 32'(wb_valid), 0);
      step();
    end
    dhit = 1'b0;
    #1;
    chk("lw_done_ren", 32'(dmemREN), 0);
    chk("lw_done_stall", 32'(mem_stall), 0);
    chk("lw_done_wbv", 32'(wb_valid), 1);
    chk("lw_done_wdat", wb_out.wdat, 32'hDEADBEEF);
    chk("lw_cnt", 32'(stall_cnt), 3);
    step();
    chk("lw_after_wbv", 32'(wb_valid), 0);

    // ---------------- SW with immediate dhit ----------------
    ex_in = '0; ex_in.MemWr = 1'b1; ex_in.aluOut = 32'h200; ex_in.rdat2 = 32'hCAFE0001;
    ex_valid = 1'b1;
    step();
    bubble();
    dhit = 1'b1;
    #1;
    chk("sw_wen", 32'(dmemWEN), 1);
    chk("sw_ren", 32'(dmemREN), 0);
    chk("sw_store", dmemstore, 32'hCAFE0001);
    chk("sw_addr", dmemaddr, 32'h200);
    step();
    dhit = 1'b0;
    #1;
    chk("sw_done_wen", 32'(dmemWEN), 0);
    chk("sw_done_wbv", 32'(wb_valid), 1);
    chk("sw_done_regwr", 32'(wb_out.RegWr), 0);
    chk("sw_cnt", 32'(stall_cnt), 4);
    step();

    // ---------------- held branch redirects on release ----------------
    ex_in = '0; ex_in.PCSrc = PC_BEQ; ex_in.zero = 1'b1; ex_in.b_addr = 32'h44;
    ex_valid = 1'b1;
    step();
    bubble();
    hold_i = 1'b1;
    #1;
    chk("hold_br0", 32'(br_taken), 0);
    step();
    chk("hold_br1", 32'(br_taken), 0);
    hold_i = 1'b0;
    #1;
    chk("hold_release_br", 32'(br_taken), 1);
    chk("hold_release_npc", npc, 32'h44);
    step();
    chk("hold_after_br", 32'(br_taken), 0);

    // ---------------- stall counter saturation ----------------
    load_lw(32'h104);
    step();
    bubble();
    repeat (13) step();
    dhit = 1'b1;
    step();
    dhit = 1'b0;
    #1;
    chk("sat_cnt", 32'(stall_cnt), CNT_MAX);
    step();

    // ---------------- reset in the middle of an access ----------------
    load_lw(32'h180);
    step();
    bubble();
    #1;
    chk("rstmid_ren_before", 32'(dmemREN), 1);
    #2;
    RST = 1'b1;
    #1;
    chk("rstmid_ren", 32'(dmemREN), 0);
    chk("rstmid_stall", 32'(mem_stall), 0);
    chk("rstmid_wbv", 32'(wb_valid), 0);
    chk("rstmid_cnt", 32'(stall_cnt), 0);
    step();
    RST = 1'b0;

    // ---------------- halt behind a pending SW ----------------
    ex_in = '0; ex_in.MemWr = 1'b1; ex_in.aluOut = 32'h300; ex_in.rdat2 = 32'h55;
    ex_valid = 1'b1;
    step();
    ex_in = '0; ex_in.halt = 1'b1; ex_valid = 1'b1;
    #1;
    chk("halt_sw_wen0", 32'(dmemWEN), 1);
    chk("halt_pre0", 32'(halt_o), 0);
    step();
    dhit = 1'b1;
    #1;
    chk("halt_sw_wen1", 32'(dmemWEN), 1);
    step();
    dhit = 1'b0;
    #1;
    chk("halt_sw_done_wbv", 32'(wb_valid), 1);
    chk("halt_sw_done_halt", 32'(wb_out.halt), 0);
    chk("halt_pre1", 32'(halt_o), 0);
    step();
    load_lw(32'h400);
    #1;
    chk("halt_wb_halt", 32'(wb_out.halt), 1);
    chk("halt_wb_valid", 32'(wb_valid), 1);
    step();
    bubble();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("halt_o%0d", c), 32'(halt_o), 1);
      chk($sformatf("halt_no_ren%0d", c), 32'(dmemREN), 0);
      step();
    end

    // ---------------- random traffic against the reference model ----------------
    do_reset();
    m_ins = '0; m_valid = 1'b0; m_busy = 1'b0; m_ldata = '0; m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        e_taken;
      logic [31:0] e_npc, e_wdat;
      int          kind;
      ex_in        = '0;
      ex_in.aluOut = $urandom; ex_in.rdat1 = $urandom; ex_in.rdat2 = $urandom;
      ex_in.b_addr = $urandom; ex_in.j_addr = $urandom; ex_in.pc = $urandom;
      ex_in.zero   = 1'($urandom_range(0, 1));
      ex_in.wsel   = 5'($urandom_range(0, 31));
      ex_in.RegWr  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 8);
      case (kind)
        1, 2:    begin ex_in.MemRd = 1'b1; ex_in.MemToReg = 1'b1; end
        3:       ex_in.MemWr = 1'b1;
        4:       ex_in.PCSrc = PC_BEQ;
        5:       ex_in.PCSrc = PC_BNE;
        6:       ex_in.PCSrc = PC_J;
        7:       ex_in.PCSrc = ($urandom_range(0, 1) == 1) ? PC_JR : PC_JAL;
        8:       begin ex_in.MemRd = 1'b1; ex_in.MemWr = 1'b1; end
        default: ;
      endcase
      ex_in.WrLinkReg = (ex_in.PCSrc == PC_JAL);
      ex_valid = ($urandom_range(0, 3) != 0);
      hold_i   = ($urandom_range(0, 3) == 0);
      dhit     = ($urandom_range(0, 2) == 0);
      dmemload = $urandom;
      #1;
      e_taken = 1'b0; e_npc = '0;
      if (m_valid && !hold_i) begin
        if (m_ins.PCSrc == PC_BEQ && m_ins.zero)  begin e_taken = 1'b1; e_npc = m_ins.b_addr; end
        if (m_ins.PCSrc == PC_BNE && !m_ins.zero) begin e_taken = 1'b1; e_npc = m_ins.b_addr; end
        if (m_ins.PCSrc == PC_J || m_ins.PCSrc == PC_JAL) begin e_taken = 1'b1; e_npc = m_ins.j_addr; end
        if (m_ins.PCSrc == PC_JR) begin e_taken = 1'b1; e_npc = m_ins.rdat1; end
      end
      e_wdat = m_ins.MemToReg ? m_ldata : (m_ins.WrLinkReg ? m_ins.pc + 32'd4 : m_ins.aluOut);
      chk("rnd_stall", 32'(mem_stall), 32'(m_busy));
      chk("rnd_ren", 32'(dmemREN), 32'(m_busy && m_ins.MemRd && !m_ins.MemWr));
      chk("rnd_wen", 32'(dmemWEN), 32'(m_busy && m_ins.MemWr));
      if (m_busy) begin
        chk("rnd_addr", dmemaddr, m_ins.aluOut);
        chk("rnd_store", dmemstore, m_ins.rdat2);
      end
      chk("rnd_wbv", 32'(wb_valid), 32'(m_valid && !m_busy));
      if (m_valid && !m_busy) begin
        chk("rnd_wdat", wb_out.wdat, e_wdat);
        chk("rnd_wsel", 32'(wb_out.wsel), 32'(m_ins.wsel));
      end
      chk("rnd_br", 32'(br_taken), 32'(e_taken));
      if (e_taken) chk("rnd_npc", npc, e_npc);
      chk("rnd_cnt", 32'(stall_cnt), m_cnt);
      @(posedge CLK);
      if (m_busy) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (dhit) begin
          m_busy = 1'b0;
          if (m_ins.MemRd && !m_ins.MemWr) m_ldata = dmemload;
        end
      end else if (!hold_i) begin
        m_ins   = ex_in;
        m_valid = ex_valid;
        m_busy  = ex_valid && (ex_in.MemRd || ex_in.MemWr);
      end
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
